// File: rtl/sr_window_reader.sv
// Tail of the pixel shift-register chain: 1-2-1 rounded average of the three taps,
// decimated by DECIM and handed off through a 2-entry valid/ready output buffer.
module sr_window_reader #(
    parameter int DECIM = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       shift_strobe,
    input  logic       line_start,
    input  logic [7:0] sr1_in,
    input  logic [7:0] sr2_in,
    input  logic [7:0] sr3_in,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       window_ready,
    output logic       overflow
);

    localparam int DATA_W = 8;
    localparam int SUM_W  = DATA_W + 2;
    localparam logic [3:0] PHASE_LAST = 4'(DECIM - 1);

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_e;

    function automatic logic [SUM_W-1:0] window_sum(input logic [DATA_W-1:0] s1,
                                                    input logic [DATA_W-1:0] s2,
                                                    input logic [DATA_W-1:0] s3);
        return {2'b00, s3} + {1'b0, s2, 1'b0} + {2'b00, s1} + SUM_W'(2);
    endfunction

    // The +2 bias is already in the sum, so dropping two LSBs rounds half-up.
    function automatic logic [DATA_W-1:0] round_sum(input logic [SUM_W-1:0] s);
        return DATA_W'(s >> 2);
    endfunction

    state_e      state_q, state_d;
    logic [1:0]  fill_q, fill_d;
    logic [3:0]  phase_q, phase_d;
    logic [1:0]  row_fill;
    logic [3:0]  row_phase;
    logic [3:0]  cur_phase;
    state_e      row_state;
    logic        keep;

    logic              vld_p1_q;
    logic [SUM_W-1:0]  sum_p1_q;
    logic [DATA_W-1:0] res_p2;

    logic [1:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] head_q, head_d;
    logic [DATA_W-1:0] tail_q, tail_d;
    logic              ovf_q, ovf_d;
    logic              pop, full, accept, drop;

    // line_start takes effect before a coincident strobe is counted.
    always_comb begin
        state_d   = state_q;
        fill_d    = fill_q;
        phase_d   = phase_q;
        keep      = 1'b0;
        cur_phase = 4'd0;
        row_fill  = line_start ? 2'd0 : fill_q;
        row_state = line_start ? FILL : state_q;
        row_phase = line_start ? 4'd0 : phase_q;

        if (line_start) begin
            state_d = FILL;
            fill_d  = 2'd0;
            phase_d = 4'd0;
        end

        if (shift_strobe) begin
            fill_d = (row_fill == 2'd3) ? 2'd3 : row_fill + 2'd1;
            if (row_state == RUN || row_fill == 2'd2) begin
                state_d   = RUN;
                cur_phase = (row_state == FILL) ? 4'd0 : row_phase;
                keep      = (cur_phase == 4'd0);
                phase_d   = (cur_phase == PHASE_LAST) ? 4'd0 : cur_phase + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            fill_q  <= 2'd0;
            phase_q <= 4'd0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            phase_q <= phase_d;
        end
    end

    assign window_ready = (fill_q == 2'd3);

    // Stage p1: window sum captured on the strobe cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1_q <= 1'b0;
        end else begin
            vld_p1_q <= keep;
        end
    end

    always_ff @(posedge clk) begin
        if (keep) begin
            sum_p1_q <= window_sum(sr1_in, sr2_in, sr3_in);
        end
    end

    // Stage p2: rounded result is written straight into the output buffer.
    assign res_p2 = round_sum(sum_p1_q);

    always_comb begin
        pop    = (cnt_q != 2'd0) && out_ready;
        full   = (cnt_q == 2'd2);
        accept = vld_p1_q && (!full || pop);
        drop   = vld_p1_q && full && !pop;
        cnt_d  = cnt_q;
        head_d = head_q;
        tail_d = tail_q;
        ovf_d  = ovf_q | drop;

        if (pop) begin
            head_d = tail_q;
            cnt_d  = cnt_q - 2'd1;
        end
        if (accept) begin
            if (cnt_d == 2'd0) begin
                head_d = res_p2;
            end else begin
                tail_d = res_p2;
            end
            cnt_d = cnt_d + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= 2'd0;
            head_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            head_q <= head_d;
            ovf_q  <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        tail_q <= tail_d;
    end

    assign out_data  = head_q;
    assign out_valid = (cnt_q != 2'd0);
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_sr_window_reader.sv
// Directed bench for sr_window_reader: one instance with DECIM=2 and one with DECIM=1
// share the same stimulus; delivered pixels are collected per instance.
module tb_sr_window_reader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       shift_strobe;
    logic       line_start;
    logic       out_ready;
    logic [7:0] sr1, sr2, sr3;

    logic [7:0] d1_data, d2_data;
    logic       d1_valid, d2_valid;
    logic       d1_wr, d2_wr;
    logic       d1_ovf, d2_ovf;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] got1[$];
    logic [7:0] got2[$];

    always #5 clk = ~clk;

    sr_window_reader #(.DECIM(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .shift_strobe(shift_strobe), .line_start(line_start),
        .sr1_in(sr1), .sr2_in(sr2), .sr3_in(sr3),
        .out_data(d2_data), .out_valid(d2_valid), .out_ready(out_ready),
        .window_ready(d2_wr), .overflow(d2_ovf)
    );

    sr_window_reader #(.DECIM(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .shift_strobe(shift_strobe), .line_start(line_start),
        .sr1_in(sr1), .sr2_in(sr2), .sr3_in(sr3),
        .out_data(d1_data), .out_valid(d1_valid), .out_ready(out_ready),
        .window_ready(d1_wr), .overflow(d1_ovf)
    );

    // Record every handshake; inputs change just after posedge, so negedge is stable.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (d1_valid && out_ready) got1.push_back(d1_data);
            if (d2_valid && out_ready) got2.push_back(d2_data);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] q1(input int i);
        return (i < got1.size()) ? 32'(got1[i]) : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] q2(input int i);
        return (i < got2.size()) ? 32'(got2[i]) : 32'hFFFF_FFFF;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                          input logic ls);
        sr1 = a; sr2 = b; sr3 = c;
        shift_strobe = 1'b1;
        line_start = ls;
        cyc();
        shift_strobe = 1'b0;
        line_start = 1'b0;
    endtask

    task automatic win(input logic [7:0] v);
        strobe(v, v, v, 1'b0);
    endtask

    task automatic restart();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();
        got1.delete();
        got2.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; shift_strobe = 1'b0; line_start = 1'b0; out_ready = 1'b0;
        sr1 = '0; sr2 = '0; sr3 = '0;
        repeat (2) cyc();
        check("rst_out_data", d2_data, 0);
        check("rst_out_valid", d2_valid, 0);
        check("rst_window_ready", d2_wr, 0);
        check("rst_overflow", d2_ovf, 0);
        check("rst_out_valid_d1", d1_valid, 0);

        // Fill and decimation: pixels 10..50 flowing through the chain.
        out_ready = 1'b1;
        restart();
        strobe(10, 0, 0, 1'b0);
        strobe(20, 10, 0, 1'b0);
        check("fill_wr_after2", d2_wr, 0);
        strobe(30, 20, 10, 1'b0);
        check("fill_wr_after3", d2_wr, 1);
        strobe(40, 30, 20, 1'b0);
        strobe(50, 40, 30, 1'b0);
        repeat (4) cyc();
        check("dec2_count", got2.size(), 2);
        check("dec2_first", q2(0), 20);
        check("dec2_second", q2(1), 40);
        check("dec1_count", got1.size(), 3);
        check("dec1_mid", q1(1), 30);

        // Rounding, width and latency.
        restart();
        win(0);
        win(0);
        win(255);
        check("lat_not_yet", d1_valid, 0);
        cyc();
        check("lat_valid", d1_valid, 1);
        check("lat_data", d1_data, 255);
        strobe(0, 0, 1, 1'b0);
        strobe(2, 0, 0, 1'b0);
        repeat (4) cyc();
        check("rnd_count", got1.size(), 3);
        check("rnd_max", q1(0), 255);
        check("rnd_down", q1(1), 0);
        check("rnd_up", q1(2), 1);
        check("rnd_d2_count", got2.size(), 2);
        check("rnd_d2_second", q2(1), 1);

        // Backpressure and overflow.
        out_ready = 1'b0;
        restart();
        win(0);
        win(0);
        win(11); win(22); win(33); win(44); win(55);
        repeat (3) cyc();
        check("bp_valid", d1_valid, 1);
        check("bp_head", d1_data, 11);
        check("bp_overflow", d1_ovf, 1);
        check("bp_overflow_d2", d2_ovf, 1);
        out_ready = 1'b1;
        repeat (4) cyc();
        check("bp_drain_count", got1.size(), 2);
        check("bp_drain_first", q1(0), 11);
        check("bp_drain_second", q1(1), 22);
        check("bp_overflow_sticky", d1_ovf, 1);
        check("bp_empty", d1_valid, 0);
        check("bp_d2_count", got2.size(), 2);
        check("bp_d2_second", q2(1), 33);

        // Push and pop on a full buffer in the same cycle.
        out_ready = 1'b0;
        restart();
        win(0);
        win(0);
        win(60);
        win(70);
        repeat (2) cyc();
        win(80);
        out_ready = 1'b1;
        repeat (4) cyc();
        check("pp_count", got1.size(), 3);
        check("pp_first", q1(0), 60);
        check("pp_second", q1(1), 70);
        check("pp_third", q1(2), 80);
        check("pp_no_overflow", d1_ovf, 0);
        check("pp_no_overflow_d2", d2_ovf, 0);

        // line_start coincident with a strobe mid-row.
        restart();
        win(0);
        win(0);
        win(100);
        strobe(120, 120, 120, 1'b1);
        check("ls_wr_cleared", d2_wr, 0);
        win(130);
        check("ls_wr_second", d1_wr, 0);
        win(140);
        check("ls_wr_third", d2_wr, 1);
        win(150);
        repeat (4) cyc();
        check("ls_d1_count", got1.size(), 3);
        check("ls_d1_inflight", q1(0), 100);
        check("ls_d1_first_new", q1(1), 140);
        check("ls_d1_next", q1(2), 150);
        check("ls_d2_count", got2.size(), 2);
        check("ls_d2_first_new", q2(1), 140);

        // Asynchronous reset with results buffered and in flight.
        out_ready = 1'b0;
        restart();
        win(0);
        win(0);
        win(200); win(201); win(202);
        win(210);
        check("ar_pre_valid", d1_valid, 1);
        check("ar_pre_overflow", d1_ovf, 1);
        #1 rst_n = 1'b0;
        #1;
        check("ar_valid", d1_valid, 0);
        check("ar_data", d1_data, 0);
        check("ar_wr", d1_wr, 0);
        check("ar_overflow", d1_ovf, 0);
        check("ar_valid_d2", d2_valid, 0);
        cyc();
        rst_n = 1'b1;
        out_ready = 1'b1;
        cyc();
        got1.delete();
        got2.delete();
        win(77);
        win(77);
        check("ar_wr_after2", d1_wr, 0);
        repeat (3) cyc();
        check("ar_none_yet", got1.size(), 0);
        win(77);
        check("ar_wr_after3", d1_wr, 1);
        repeat (3) cyc();
        check("ar_count", got1.size(), 1);
        check("ar_first", q1(0), 77);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
